// File: rtl/pc_gen.sv
// pc_gen: program counter and instruction fetch request generator.
// Drives the imem req/ack handshake and the IF/ID write strobe.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall_i           downstream stall (hold PC, no IF/ID write)
//   branch_i          redirect to branch_target_i (low bits aligned)
//   branch_target_i   branch/jump target
//   exc_i             redirect to EXC_VEC (beats branch_i)
//   imem_req_o        fetch request, address is pc_o
//   imem_ack_i        fetch complete this cycle
//   pc_o              current fetch address
//   ce_o              instruction memory chip enable
//   ifid_wd_o         one-cycle IF/ID write strobe
//   ifid_pc_o         PC of the instruction written on ifid_wd_o
module pc_gen #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC  = '0,
    parameter logic [ADDR_W-1:0]  EXC_VEC    = ADDR_W'(32'h0000_0020),
    parameter int                 INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              exc_i,
    output logic              imem_req_o,
    input  logic              imem_ack_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic              ifid_wd_o,
    output logic [ADDR_W-1:0] ifid_pc_o
);

    typedef enum logic [1:0] {
        S_RST,
        S_FETCH,
        S_HOLD,
        S_DISCARD
    } state_t;

    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INST_BYTES);
    // Clears the low log2(INST_BYTES) bits of a branch target.
    localparam logic [ADDR_W-1:0] ALIGN = ~(STEP - 1'b1);

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic [ADDR_W-1:0] tgt_q, tgt_n;
    logic [ADDR_W-1:0] ifpc_n;
    logic              ce_n;
    logic              wd_n;
    logic              redir;
    logic [ADDR_W-1:0] redir_tgt;

    assign redir     = exc_i | branch_i;
    assign redir_tgt = exc_i ? EXC_VEC : (branch_target_i & ALIGN);

    // Only S_FETCH has a request on the bus; HOLD already owns its
    // instruction and DISCARD is waiting out a stale one.
    assign imem_req_o = (state_q == S_FETCH);

    always_comb begin
        state_n = state_q;
        pc_n    = pc_o;
        tgt_n   = tgt_q;
        ifpc_n  = ifid_pc_o;
        ce_n    = ce_o;
        wd_n    = 1'b0;
        unique case (state_q)
            S_RST: begin
                ce_n    = 1'b1;
                state_n = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    if (redir) begin
                        pc_n = redir_tgt;
                    end else if (stall_i) begin
                        state_n = S_HOLD;
                    end else begin
                        wd_n   = 1'b1;
                        ifpc_n = pc_o;
                        pc_n   = pc_o + STEP;
                    end
                end else if (redir) begin
                    // Request already issued: remember where to go
                    // and throw away whatever comes back.
                    tgt_n   = redir_tgt;
                    state_n = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_n    = redir_tgt;
                    state_n = S_FETCH;
                end else if (!stall_i) begin
                    wd_n    = 1'b1;
                    ifpc_n  = pc_o;
                    pc_n    = pc_o + STEP;
                    state_n = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (redir) begin
                    tgt_n = redir_tgt;
                end
                if (imem_ack_i) begin
                    pc_n    = redir ? redir_tgt : tgt_q;
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RST;
            pc_o      <= RESET_VEC;
            tgt_q     <= '0;
            ce_o      <= 1'b0;
            ifid_wd_o <= 1'b0;
            ifid_pc_o <= '0;
        end else begin
            state_q   <= state_n;
            pc_o      <= pc_n;
            tgt_q     <= tgt_n;
            ce_o      <= ce_n;
            ifid_wd_o <= wd_n;
            ifid_pc_o <= ifpc_n;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic for pc_gen,
// checked against a transaction-level fetch model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] bt = '0;
    logic        exc = 1'b0;
    logic        ack = 1'b0;

    logic        req, ce, wd;
    logic [31:0] pc, ifpc;

    logic [15:0] bt16;
    logic        req16, ce16, wd16;
    logic [15:0] pc16, ifpc16;

    assign bt16 = bt[15:0];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall),
        .branch_i       (br),
        .branch_target_i(bt),
        .exc_i          (exc),
        .imem_req_o     (req),
        .imem_ack_i     (ack),
        .pc_o           (pc),
        .ce_o           (ce),
        .ifid_wd_o      (wd),
        .ifid_pc_o      (ifpc)
    );

    pc_gen #(
        .ADDR_W   (16),
        .RESET_VEC(16'h0000),
        .EXC_VEC  (16'h0020)
    ) dut16 (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall),
        .branch_i       (br),
        .branch_target_i(bt16),
        .exc_i          (exc),
        .imem_req_o     (req16),
        .imem_ack_i     (ack),
        .pc_o           (pc16),
        .ce_o           (ce16),
        .ifid_wd_o      (wd16),
        .ifid_pc_o      (ifpc16)
    );

    // Reference model: out of reset or not, whether an instruction
    // is parked behind a stall, whether a stale fetch must be dropped.
    bit          m_up   = 1'b0;
    bit          m_held = 1'b0;
    bit          m_drop = 1'b0;
    logic [31:0] m_dest = '0;
    logic [31:0] m_pc   = '0;
    logic        m_wd   = 1'b0;
    logic [31:0] m_ifpc = '0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, s, b,
                              input logic [31:0] t,
                              input bit e, a);
        logic [31:0] where;
        bit          jump;
        jump  = e || b;
        where = e ? 32'h20 : {t[31:2], 2'b00};
        m_wd  = 1'b0;
        if (r) begin
            m_up   = 1'b0;
            m_held = 1'b0;
            m_drop = 1'b0;
            m_pc   = 32'h0;
            m_ifpc = 32'h0;
        end else if (!m_up) begin
            m_up = 1'b1;
        end else if (m_drop) begin
            if (jump) m_dest = where;
            if (a) begin
                m_pc   = m_dest;
                m_drop = 1'b0;
            end
        end else if (m_held) begin
            if (jump) begin
                m_pc   = where;
                m_held = 1'b0;
            end else if (!s) begin
                m_wd   = 1'b1;
                m_ifpc = m_pc;
                m_pc   = m_pc + 32'd4;
                m_held = 1'b0;
            end
        end else if (a) begin
            if (jump) m_pc = where;
            else if (s) m_held = 1'b1;
            else begin
                m_wd   = 1'b1;
                m_ifpc = m_pc;
                m_pc   = m_pc + 32'd4;
            end
        end else if (jump) begin
            m_drop = 1'b1;
            m_dest = where;
        end
    endtask

    task automatic cyc(input bit r, s, b,
                       input logic [31:0] t,
                       input bit e, a);
        rst   = r;
        stall = s;
        br    = b;
        bt    = t;
        exc   = e;
        ack   = a;
        @(negedge clk);
        chk("pc", pc, m_pc);
        chk("req", {31'd0, req}, {31'd0, m_up && !m_held && !m_drop});
        chk("ce", {31'd0, ce}, {31'd0, m_up});
        chk("wd", {31'd0, wd}, {31'd0, m_wd});
        chk("ifpc", ifpc, m_ifpc);
        @(posedge clk);
        model_step(r, s, b, t, e, a);
        #1;
    endtask

    initial begin
        // Reset then free-run with ack held high.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        chk("rst_ce", {31'd0, ce}, 32'd0);
        chk("rst_req", {31'd0, req}, 32'd0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("ce_rise", {31'd0, ce}, 32'd1);
        chk("req_rise", {31'd0, req}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            chk("seq_wd", {31'd0, wd}, 32'd1);
            chk("seq_ifpc", ifpc, 32'(i * 4));
        end
        chk("seq_pc", pc, 32'h10);

        // Stall coincident with ack at 0x10.
        cyc(0, 1, 0, 0, 0, 1);
        chk("hold_req", {31'd0, req}, 32'd0);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        chk("hold_pc", pc, 32'h10);
        chk("hold_wd", {31'd0, wd}, 32'd0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("unstall_wd", {31'd0, wd}, 32'd1);
        chk("unstall_ifpc", ifpc, 32'h10);
        chk("unstall_pc", pc, 32'h14);

        // Branch with ack at 0x20: squash, realign target.
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("pre_br_pc", pc, 32'h20);
        cyc(0, 0, 1, 32'h1003, 0, 1);
        chk("br_squash", {31'd0, wd}, 32'd0);
        chk("br_pc", pc, 32'h1000);
        cyc(0, 0, 0, 0, 0, 1);
        chk("br_ifpc", ifpc, 32'h1000);

        // Branch while a fetch at 0x40 is outstanding.
        cyc(0, 0, 1, 32'h40, 0, 1);
        cyc(0, 0, 1, 32'h200, 0, 0);
        chk("disc_req", {31'd0, req}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("disc_wd", {31'd0, wd}, 32'd0);
        chk("disc_pc", pc, 32'h200);
        chk("disc_req2", {31'd0, req}, 32'd1);

        // Exception beats branch; reset mid-fetch ignores the ack.
        cyc(0, 0, 1, 32'h300, 1, 1);
        chk("exc_pc", pc, 32'h20);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_wd", {31'd0, wd}, 32'd0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("post_rst_wd", {31'd0, wd}, 32'd0);
        chk("post_rst_pc", pc, 32'h0);

        // Wrap at the top of the address space (16 and 32 bit).
        cyc(0, 0, 1, 32'h0000_FFFC, 0, 1);
        chk("w16_pc_top", {16'd0, pc16}, 32'hFFFC);
        cyc(0, 0, 0, 0, 0, 1);
        chk("w16_ifpc", {16'd0, ifpc16}, 32'hFFFC);
        chk("w16_pc", {16'd0, pc16}, 32'h0);
        cyc(0, 0, 1, 32'hFFFF_FFFF, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("w32_ifpc", ifpc, 32'hFFFF_FFFC);
        chk("w32_pc", pc, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          r, s, b, e, a;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 99) < 10);
            e = ($urandom_range(0, 99) < 4);
            a = ($urandom_range(0, 99) < 60);
            t = $urandom();
            if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | t[3:0];
            cyc(r, s, b, t, e, a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
